// File: rtl/finv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : finv_arbiter
// Brief    : Round-robin arbiter sharing one pipelined reciprocal unit (finv)
//            among NREQ requesters. A tag pipeline matched to the finv latency
//            steers every result back to the requester that issued it.
//            A drain control quiesces the unit before mode changes or halt.
// Options  : define FINV_ARB_STATS_EN to add saturating per-requester grant
//            counters on output grant_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module finv_arbiter #(
    parameter int NREQ = 4,
    parameter int LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [31:0]          finv_a,
    input  logic [31:0]          finv_s,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [31:0]          rsp_data,
    input  logic                 drain,
`ifdef FINV_ARB_STATS_EN
    output logic [16*NREQ-1:0]   grant_cnt,
`endif
    output logic                 idle
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_DRAINING = 2'd1,
        ST_DRAINED  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_PTR_W-1:0]   r_ptr;
    logic [31:0]          r_finv_a;
    logic [LAT:0]         r_tag_vld;
    logic [c_PTR_W-1:0]   r_tag_idx [0:LAT];

    logic [NREQ-1:0]      w_grant;
    logic [c_PTR_W-1:0]   w_grant_idx;
    logic                 w_found;
    logic                 w_run;
    logic                 w_accept;
    logic [31:0]          w_grant_data;
    logic                 w_idle;

    // Round-robin search: first valid requester above ptr, wrapping modulo NREQ
    always_comb begin
        int j;
        w_grant     = '0;
        w_grant_idx = '0;
        w_found     = 1'b0;
        j           = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(r_ptr) + k) % NREQ;
            if (!w_found && req_valid[j]) begin
                w_found     = 1'b1;
                w_grant_idx = c_PTR_W'(j);
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_idx == c_PTR_W'(i)) begin
                w_grant_data = req_data[32*i +: 32];
            end
        end
    end

    // Grants only in RUN, and never while reset is held
    assign w_run     = rst_n && (r_state == ST_RUN);
    assign w_accept  = w_run && w_found;
    assign req_ready = w_run ? w_grant : '0;

    assign w_idle    = ~|r_tag_vld;
    assign idle      = w_idle;
    assign finv_a    = r_finv_a;
    assign rsp_data  = finv_s;

    // Drain control: stop granting, then report drained once nothing is in flight
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain) w_state_nxt = ST_DRAINING;
            end
            ST_DRAINING: begin
                if (!drain)     w_state_nxt = ST_RUN;
                else if (w_idle) w_state_nxt = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pointer and operand register update on accept; ptr reset makes requester 0 win first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= c_PTR_W'(NREQ - 1);
            r_finv_a <= '0;
        end else if (w_accept) begin
            r_ptr    <= w_grant_idx;
            r_finv_a <= w_grant_data;
        end
    end

    // Tag pipeline of depth 1+LAT: entry 0 aligns with finv_a, last entry with finv_s
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i <= LAT; i++) begin
                r_tag_idx[i] <= '0;
            end
        end else begin
            r_tag_vld    <= {r_tag_vld[LAT-1:0], w_accept};
            r_tag_idx[0] <= w_grant_idx;
            for (int i = 1; i <= LAT; i++) begin
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    // Response steering from the oldest tag
    always_comb begin
        rsp_valid = '0;
        if (r_tag_vld[LAT]) begin
            rsp_valid[r_tag_idx[LAT]] = 1'b1;
        end
    end

`ifdef FINV_ARB_STATS_EN
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
            logic [15:0] r_cnt;

            // Saturating accept counter for requester gi
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_grant_idx == c_PTR_W'(gi)) &&
                             (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign grant_cnt[16*gi +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: doc/finv_arbiter.md
# finv_arbiter

Round-robin arbiter that shares one pipelined reciprocal unit (`finv`, fixed 3-cycle latency, no backpressure) among NREQ requesters. It accepts at most one operand per cycle and drives the registered operand into the `finv` instance. Each operand's requester index travels through a tag pipeline matched to the `finv` latency, so each result is steered back to the requester that issued it. A drain control lets the surrounding control logic quiesce the unit before mode changes or halting.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `LAT`, 3: `finv` latency in cycles from its `a` input to its `s` output. Must match the instantiated `finv`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input NREQ: bit i high means requester i offers an operand.
- `req_data` input 32*NREQ: operand of requester i at bits [32i+31:32i], IEEE single.
- `req_ready` output NREQ: one-hot or zero. Bit i high means requester i's operand is accepted this cycle.
- `finv_a` output 32: registered operand to the `finv` `a` input.
- `finv_s` input 32: result from the `finv` `s` output.
- `rsp_valid` output NREQ: one-hot or zero. Bit i high means `rsp_data` belongs to requester i.
- `rsp_data` output 32: result, equal to `finv_s`.
- `drain` input 1: when high, stop accepting new operands.
- `idle` output 1: no accepted operand is still in flight.

## Operation
- Arbitration is combinational within the cycle.
  - Among the set bits of `req_valid`, grant the first index found searching upward from `ptr+1`, wrapping modulo NREQ.
  - `req_ready` is the one-hot grant, gated by state == RUN.
- On an accept (any `req_ready` bit high):
  - `finv_a` <= `req_data` of the granted requester.
  - `ptr` <= granted index.
  - The tag pipeline entry 0 loads {valid=1, idx=granted}.
- With no accept, `finv_a` holds its value and tag entry 0 loads valid=0.
- Tag pipeline: depth 1+LAT, shifting every cycle. The last entry drives `rsp_valid` = valid ? onehot(idx) : 0.
- `rsp_data` = `finv_s`. No registering; there is no response backpressure. Requesters must consume `rsp_data` in the cycle `rsp_valid` is high.
- State machine, encoded in 2 bits:
  - RUN: grants allowed. If `drain`=1, go to DRAINING next cycle.
  - DRAINING: no grants. When `drain`=1 and the pipeline is empty, go to DRAINED. When `drain`=0, go to RUN.
  - DRAINED: no grants. When `drain`=0, go to RUN.
- `drain` sampled high in RUN does not block a grant in that same cycle. Blocking starts the following cycle.
- `idle` = all tag valid bits are 0. It is combinational from the registered state.
- `ptr` is log2(NREQ) bits wide. Wrap-around: after granting NREQ-1, the search starts at index 0.
- A requester whose `req_valid` is not set is skipped without penalty. A single active requester is granted every cycle.

## Timing
- Reset values:
  - `ptr` = NREQ-1, so requester 0 wins first.
  - State = RUN.
  - All tag valid bits 0.
  - `finv_a` = 0.
  - `rsp_valid` = 0 and `idle` = 1.
  - `req_ready` = 0 while `rst_n` is low.
- Accept in cycle T leads to `rsp_valid` in cycle T+1+LAT (T+4 by default).
- Throughput: one operand per cycle. Results return in accept order.
- Reset mid-operation clears all tags. Stale `finv_s` values never raise `rsp_valid`.
- Simultaneous accept and response in one cycle is legal and independent of each other.

## Configuration
- Macro: `FINV_ARB_STATS_EN`.
- With the macro defined:
  - Adds output `grant_cnt`, 16*NREQ bits wide.
  - Counter i sits at bits [16i+15:16i] and increments on each accept of requester i.
  - Counters saturate at 0xFFFF and reset to 0 via `rst_n`.
- Without the macro, the port and counters are absent. Behaviour is otherwise identical.

## Test plan
- Single request: requester 2 offers 0x40000000 in cycle 5 with the others idle. Expect `req_ready`=0b0100 in cycle 5, `rsp_valid`=0b0100 in cycle 9, and `rsp_data` equal to a standalone `finv` result for 0x40000000. `idle` is 0 in cycles 6–9.
- Contention: all four requesters hold valid from reset release. Expect grants 0,1,2,3,0,… on consecutive cycles and `rsp_valid` in the same order 4 cycles later, with no gaps.
- Sparse wrap: only requesters 1 and 3 are valid, with `ptr`=3. Expect grant order 1,3,1,3. Requesters 0 and 2 are never granted.
- Drain:
  - Assert `drain` one cycle after a grant in cycle T. Expect no grants from T+2 onward.
  - `idle`=1 and state DRAINED once the last response is delivered.
  - Deassert `drain`; the next cycle grants resume.
- Reset mid-flight: three operands accepted, then `rst_n` pulsed low in the next cycle. Expect no `rsp_valid` afterwards, all outputs at reset values, and `ptr`=NREQ-1 (first grant to requester 0).
- Stats (with `FINV_ARB_STATS_EN`): 70000 back-to-back accepts by requester 0. Expect `grant_cnt[15:0]`=0xFFFF and the other counters at 0.
